// File: rtl/vmx_pkg.sv
// -----------------------------------------------------------------------------
// vmx_pkg
// Shared definitions for the VMX queue consumers.
//   - mac_state_t   : 2-bit state encoding of the memory access processor
//   - WORD_OFS_BITS : number of byte-offset bits inside a memory word
//   - WORD_OFS_MASK : mask selecting the byte-offset bits of an address
//   - is_misaligned : true when the byte-offset bits of an address are non-zero
// The control processor builds its queue command words from the same
// alignment constants, so both sides agree on what "word aligned" means.
// -----------------------------------------------------------------------------
package vmx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_WAIT = 2'd3
  } mac_state_t;

  localparam int                      WORD_OFS_BITS = 2;
  localparam logic [WORD_OFS_BITS-1:0] WORD_OFS_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [WORD_OFS_BITS-1:0] ofs);
    return |(ofs & WORD_OFS_MASK);
  endfunction

endpackage

// File: rtl/vmx_mem_access_processor.sv
// -----------------------------------------------------------------------------
// vmx_mem_access_processor
// Consumer end of the read/write command queues filled by the control
// processor. Read commands become single-beat memory reads whose data is
// pushed into the load FIFO feeding the PE array; write commands are paired
// with PE result words and become single-beat memory writes. When both kinds
// of work are available in the same cycle the write goes first.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   rd_fifo_instr/empty/rena   read-address queue (first-word-fall-through)
//   wr_fifo_instr/empty/rena   write-address queue (FWFT)
//   res_fifo_data/empty/rena   PE result queue (FWFT), supplies write data
//   ld_fifo_data/full/wren     load FIFO towards the PE array
//   mem_req_*                  memory request channel (valid/ready)
//   mem_rsp_valid/rdata        memory read response, one cycle per read
//   busy                       engine is not idle
//   err_misaligned             sticky, a popped address had byte-offset bits
//   err_spurious_rsp           sticky, a response arrived outside RD_WAIT
//   rd_done_cnt, wr_done_cnt   completed transaction counters (wrapping)
// -----------------------------------------------------------------------------
module vmx_mem_access_processor
  import vmx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] rd_fifo_instr,
  input  logic              rd_fifo_empty,
  output logic              rd_fifo_rena,

  input  logic [ADDR_W-1:0] wr_fifo_instr,
  input  logic              wr_fifo_empty,
  output logic              wr_fifo_rena,

  input  logic [DATA_W-1:0] res_fifo_data,
  input  logic              res_fifo_empty,
  output logic              res_fifo_rena,

  output logic [DATA_W-1:0] ld_fifo_data,
  input  logic              ld_fifo_full,
  output logic              ld_fifo_wren,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,

  output logic              busy,
  output logic              err_misaligned,
  output logic              err_spurious_rsp,
  output logic [CNT_W-1:0]  rd_done_cnt,
  output logic [CNT_W-1:0]  wr_done_cnt
);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  mac_state_t        r_state;
  logic              r_req_valid;
  logic              r_req_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_err_misaligned;
  logic              r_err_spurious;
  logic [CNT_W-1:0]  r_rd_done_cnt;
  logic [CNT_W-1:0]  r_wr_done_cnt;

  // ---------------------------------------------------------------------------
  // Arbitration and pop decode
  // ---------------------------------------------------------------------------
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_idle;
  logic              w_pop_wr;
  logic              w_pop_rd;
  logic [ADDR_W-1:0] w_pop_addr;
  logic [ADDR_W-1:0] w_pop_addr_aligned;
  logic              w_rsp_accept;

  assign w_wr_ok = ~wr_fifo_empty & ~res_fifo_empty;
  // Checking ld_fifo_full before issuing reserves the load slot: nothing else
  // writes the load FIFO, so the slot is still free when the response returns.
  assign w_rd_ok = ~rd_fifo_empty & ~ld_fifo_full;

  // rst_n gates the pop strobes so nothing is consumed while reset is held.
  assign w_idle   = rst_n && (r_state == ST_IDLE);
  assign w_pop_wr = w_idle && w_wr_ok;
  assign w_pop_rd = w_idle && !w_wr_ok && w_rd_ok;

  assign w_pop_addr         = w_pop_wr ? wr_fifo_instr : rd_fifo_instr;
  assign w_pop_addr_aligned = w_pop_addr & ~ADDR_W'(WORD_OFS_MASK);

  // A response is only taken in RD_WAIT; one arriving together with the
  // request acceptance (still RD_REQ) is treated as spurious.
  assign w_rsp_accept = rst_n && (r_state == ST_RD_WAIT) && mem_rsp_valid;

  // ---------------------------------------------------------------------------
  // FSM with registered request outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_req_valid      <= 1'b0;
      r_req_we         <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_busy           <= 1'b0;
      r_err_misaligned <= 1'b0;
      r_err_spurious   <= 1'b0;
      r_rd_done_cnt    <= '0;
      r_wr_done_cnt    <= '0;
    end else begin
      if (mem_rsp_valid && (r_state != ST_RD_WAIT)) begin
        r_err_spurious <= 1'b1;
      end

      if ((w_pop_wr || w_pop_rd) && is_misaligned(w_pop_addr[WORD_OFS_BITS-1:0])) begin
        r_err_misaligned <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop_wr) begin
            r_addr      <= w_pop_addr_aligned;
            r_wdata     <= res_fifo_data;
            r_req_valid <= 1'b1;
            r_req_we    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_WR_REQ;
          end else if (w_pop_rd) begin
            r_addr      <= w_pop_addr_aligned;
            r_req_valid <= 1'b1;
            r_req_we    <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_RD_REQ;
          end
        end

        ST_WR_REQ: begin
          // Address and data stay registered until the memory accepts them.
          if (mem_req_ready) begin
            r_wr_done_cnt <= r_wr_done_cnt + CNT_W'(1);
            r_req_valid   <= 1'b0;
            r_req_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end

        ST_RD_REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (mem_rsp_valid) begin
            r_rd_done_cnt <= r_rd_done_cnt + CNT_W'(1);
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_req_valid <= 1'b0;
          r_req_we    <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_fifo_rena  = w_pop_wr;
  assign res_fifo_rena = w_pop_wr;
  assign rd_fifo_rena  = w_pop_rd;

  // Read data is forwarded straight from the memory in the response cycle.
  assign ld_fifo_wren = w_rsp_accept;
  assign ld_fifo_data = w_rsp_accept ? mem_rsp_rdata : '0;

  assign mem_req_valid = r_req_valid;
  assign mem_req_we    = r_req_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;

  assign busy             = r_busy;
  assign err_misaligned   = r_err_misaligned;
  assign err_spurious_rsp = r_err_spurious;
  assign rd_done_cnt      = r_rd_done_cnt;
  assign wr_done_cnt      = r_wr_done_cnt;

endmodule

// File: tb/tb_vmx_mem_access_processor.sv
// -----------------------------------------------------------------------------
// tb_vmx_mem_access_processor
// Directed scenarios plus a randomized run against a transaction-level model
// (command queues, a sparse memory and a pending-request record).
// CNT_W is narrowed so the counter wrap is reached after a few hundred writes.
// -----------------------------------------------------------------------------
module tb_vmx_mem_access_processor;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_fifo_instr;
  logic              rd_fifo_empty;
  logic              rd_fifo_rena;
  logic [ADDR_W-1:0] wr_fifo_instr;
  logic              wr_fifo_empty;
  logic              wr_fifo_rena;
  logic [DATA_W-1:0] res_fifo_data;
  logic              res_fifo_empty;
  logic              res_fifo_rena;
  logic [DATA_W-1:0] ld_fifo_data;
  logic              ld_fifo_full;
  logic              ld_fifo_wren;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              busy;
  logic              err_misaligned;
  logic              err_spurious_rsp;
  logic [CNT_W-1:0]  rd_done_cnt;
  logic [CNT_W-1:0]  wr_done_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  vmx_mem_access_processor #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_fifo_instr   (rd_fifo_instr),
    .rd_fifo_empty   (rd_fifo_empty),
    .rd_fifo_rena    (rd_fifo_rena),
    .wr_fifo_instr   (wr_fifo_instr),
    .wr_fifo_empty   (wr_fifo_empty),
    .wr_fifo_rena    (wr_fifo_rena),
    .res_fifo_data   (res_fifo_data),
    .res_fifo_empty  (res_fifo_empty),
    .res_fifo_rena   (res_fifo_rena),
    .ld_fifo_data    (ld_fifo_data),
    .ld_fifo_full    (ld_fifo_full),
    .ld_fifo_wren    (ld_fifo_wren),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_rdata   (mem_rsp_rdata),
    .busy            (busy),
    .err_misaligned  (err_misaligned),
    .err_spurious_rsp(err_spurious_rsp),
    .rd_done_cnt     (rd_done_cnt),
    .wr_done_cnt     (wr_done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled a
  // further unit later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_fifo_instr  = '0;
    rd_fifo_empty  = 1'b1;
    wr_fifo_instr  = '0;
    wr_fifo_empty  = 1'b1;
    res_fifo_data  = '0;
    res_fifo_empty = 1'b1;
    ld_fifo_full   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr(input bit allow_mis);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom_range(0, 63)) * 4;
    if (allow_mis && ($urandom_range(0, 9) == 0)) a = a + ADDR_W'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n          = 1'b0;
    rd_fifo_empty  = 1'b0;
    rd_fifo_instr  = 32'h0000_0044;
    wr_fifo_empty  = 1'b0;
    wr_fifo_instr  = 32'h0000_0088;
    res_fifo_empty = 1'b0;
    res_fifo_data  = 32'hCAFE_F00D;
    mem_rsp_valid  = 1'b1;
    mem_rsp_rdata  = 32'h1111_2222;
    tick();
    tick();
    #1;
    checks++;
    if ({rd_fifo_rena, wr_fifo_rena, res_fifo_rena, ld_fifo_wren, mem_req_valid,
         mem_req_we, busy, err_misaligned, err_spurious_rsp} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {rd_fifo_rena, wr_fifo_rena, res_fifo_rena, ld_fifo_wren, mem_req_valid,
                mem_req_we, busy, err_misaligned, err_spurious_rsp});
    end
    checks++;
    if (mem_req_addr !== '0 || mem_req_wdata !== '0 || ld_fifo_data !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h ld=%h want all 0", mem_req_addr, mem_req_wdata, ld_fifo_data);
    end
    checks++;
    if (rd_done_cnt !== '0 || wr_done_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: rd=%0d wr=%0d want 0", rd_done_cnt, wr_done_cnt);
    end
    idle_inputs();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_read();
    do_reset();
    rd_fifo_instr = 32'h0000_0010;
    rd_fifo_empty = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    rd_fifo_empty = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrd_wait: busy=%b valid=%b want busy=1 valid=0", busy, mem_req_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0077;
    #1;
    checks++;
    if (ld_fifo_wren !== 1'b0) begin
      errors++;
      $display("FAIL midrd_wren: got %b want 0", ld_fifo_wren);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (err_spurious_rsp !== 1'b1 || busy !== 1'b0 || rd_done_cnt !== '0) begin
      errors++;
      $display("FAIL midrd_after: spurious=%b busy=%b rd_cnt=%0d want 1 0 0",
               err_spurious_rsp, busy, rd_done_cnt);
    end
    $display("test_reset_mid_read done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_write();
    int hold, bad, wpulse, rpulse;
    do_reset();
    wr_fifo_instr  = 32'h1000_0010;
    wr_fifo_empty  = 1'b0;
    res_fifo_data  = 32'hDEAD_BEEF;
    res_fifo_empty = 1'b0;
    #1;
    checks++;
    if (wr_fifo_rena !== 1'b1 || res_fifo_rena !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_pop: wr_rena=%b res_rena=%b valid=%b want 1 1 0", wr_fifo_rena, res_fifo_rena, mem_req_valid);
    end
    wpulse = int'(wr_fifo_rena);
    rpulse = int'(res_fifo_rena);
    hold   = 0;
    bad    = 0;
    tick();
    wr_fifo_empty  = 1'b1;
    res_fifo_empty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_req_ready = (i == 3);
      #1;
      if (mem_req_valid === 1'b1) begin
        hold++;
        if (mem_req_we !== 1'b1 || mem_req_addr !== 32'h1000_0010 || mem_req_wdata !== 32'hDEAD_BEEF) bad++;
      end
      wpulse += int'(wr_fifo_rena);
      rpulse += int'(res_fifo_rena);
      tick();
      mem_req_ready = 1'b0;
    end
    checks++;
    if (hold != 4 || bad != 0) begin
      errors++;
      $display("FAIL wr_hold: valid cycles=%0d bad=%0d want 4 0", hold, bad);
    end
    checks++;
    if (wpulse != 1 || rpulse != 1) begin
      errors++;
      $display("FAIL wr_pulses: wr=%0d res=%0d want 1 1", wpulse, rpulse);
    end
    #1;
    checks++;
    if (wr_done_cnt !== CNT_W'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: cnt=%0d busy=%b want 1 0", wr_done_cnt, busy);
    end
    $display("test_single_write done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    do_reset();
    rd_fifo_instr  = 32'h0000_0100;
    rd_fifo_empty  = 1'b0;
    wr_fifo_instr  = 32'h0000_0200;
    wr_fifo_empty  = 1'b0;
    res_fifo_data  = 32'h0000_0005;
    res_fifo_empty = 1'b0;
    mem_req_ready  = 1'b1;
    #1;
    checks++;
    if ({wr_fifo_rena, res_fifo_rena, rd_fifo_rena} !== 3'b110) begin
      errors++;
      $display("FAIL sim_prio: wr/res/rd rena=%b want 110", {wr_fifo_rena, res_fifo_rena, rd_fifo_rena});
    end
    tick();
    wr_fifo_empty  = 1'b1;
    res_fifo_empty = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 32'h200 ||
        mem_req_wdata !== 32'h5 || rd_fifo_rena !== 1'b0) begin
      errors++;
      $display("FAIL sim_wr: valid=%b we=%b addr=%h wdata=%h rd_rena=%b want 1 1 200 5 0",
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, rd_fifo_rena);
    end
    tick();
    #1;
    checks++;
    if (rd_fifo_rena !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL sim_rdpop: rd_rena=%b valid=%b want 1 0", rd_fifo_rena, mem_req_valid);
    end
    tick();
    rd_fifo_empty = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL sim_rd: valid=%b we=%b addr=%h want 1 0 100", mem_req_valid, mem_req_we, mem_req_addr);
    end
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0ABC;
    #1;
    checks++;
    if (ld_fifo_wren !== 1'b1 || ld_fifo_data !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL sim_ld: wren=%b data=%h want 1 00000abc", ld_fifo_wren, ld_fifo_data);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (rd_done_cnt !== CNT_W'(1) || wr_done_cnt !== CNT_W'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL sim_cnt: rd=%0d wr=%0d busy=%b want 1 1 0", rd_done_cnt, wr_done_cnt, busy);
    end
    $display("test_simultaneous done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_blocked();
    do_reset();
    wr_fifo_instr = 32'h0000_0300;
    wr_fifo_empty = 1'b0;
    rd_fifo_instr = 32'h0000_0040;
    rd_fifo_empty = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if ({wr_fifo_rena, res_fifo_rena, rd_fifo_rena} !== 3'b001) begin
      errors++;
      $display("FAIL blk_pop: wr/res/rd rena=%b want 001", {wr_fifo_rena, res_fifo_rena, rd_fifo_rena});
    end
    tick();
    rd_fifo_empty = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h40) begin
      errors++;
      $display("FAIL blk_rd: valid=%b we=%b addr=%h want 1 0 40", mem_req_valid, mem_req_we, mem_req_addr);
    end
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0007;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (wr_fifo_rena !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL blk_wait: wr_rena=%b busy=%b want 0 0", wr_fifo_rena, busy);
    end
    tick();
    res_fifo_data  = 32'h0000_0099;
    res_fifo_empty = 1'b0;
    #1;
    checks++;
    if (wr_fifo_rena !== 1'b1 || res_fifo_rena !== 1'b1) begin
      errors++;
      $display("FAIL blk_wrpop: wr_rena=%b res_rena=%b want 1 1", wr_fifo_rena, res_fifo_rena);
    end
    tick();
    wr_fifo_empty  = 1'b1;
    res_fifo_empty = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 32'h300 || mem_req_wdata !== 32'h99) begin
      errors++;
      $display("FAIL blk_wr: valid=%b we=%b addr=%h wdata=%h want 1 1 300 99",
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
    end
    tick();
    mem_req_ready = 1'b0;
    $display("test_write_blocked done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ld_full();
    int early, wren_cnt;
    do_reset();
    rd_fifo_instr = 32'h0000_0080;
    rd_fifo_empty = 1'b0;
    ld_fifo_full  = 1'b1;
    early         = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rd_fifo_rena !== 1'b0 || mem_req_valid !== 1'b0) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL full_block: %0d cycles with rena/request want 0", early);
    end
    ld_fifo_full = 1'b0;
    #1;
    checks++;
    if (rd_fifo_rena !== 1'b1) begin
      errors++;
      $display("FAIL full_release: rd_rena=%b want 1", rd_fifo_rena);
    end
    tick();
    rd_fifo_empty = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h80) begin
      errors++;
      $display("FAIL full_req: valid=%b we=%b addr=%h want 1 0 80", mem_req_valid, mem_req_we, mem_req_addr);
    end
    tick();
    mem_req_ready = 1'b0;
    ld_fifo_full  = 1'b1;   // not looked at while waiting for the response
    wren_cnt      = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = (i == 1);
      mem_rsp_rdata = (i == 1) ? 32'h0000_1234 : 32'hFFFF_FFFF;
      #1;
      if (ld_fifo_wren === 1'b1) begin
        wren_cnt++;
        checks++;
        if (ld_fifo_data !== 32'h0000_1234) begin
          errors++;
          $display("FAIL full_lddata: got %h want 00001234", ld_fifo_data);
        end
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
    ld_fifo_full  = 1'b0;
    checks++;
    if (wren_cnt != 1) begin
      errors++;
      $display("FAIL full_wren: pulses=%0d want 1", wren_cnt);
    end
    $display("test_ld_full done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_misaligned_spurious();
    do_reset();
    rd_fifo_instr = 32'h0000_0103;
    rd_fifo_empty = 1'b0;
    #1;
    checks++;
    if (err_misaligned !== 1'b0 || rd_fifo_rena !== 1'b1) begin
      errors++;
      $display("FAIL mis_pre: err=%b rd_rena=%b want 0 1", err_misaligned, rd_fifo_rena);
    end
    tick();
    rd_fifo_empty = 1'b1;
    #1;
    checks++;
    if (mem_req_addr !== 32'h100 || mem_req_valid !== 1'b1 || err_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL mis_addr: addr=%h valid=%b err=%b want 100 1 1", mem_req_addr, mem_req_valid, err_misaligned);
    end
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0055;
    #1;
    checks++;
    if (ld_fifo_wren !== 1'b0) begin
      errors++;
      $display("FAIL spur_early: wren=%b want 0", ld_fifo_wren);
    end
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (err_spurious_rsp !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL spur_flag: spurious=%b busy=%b want 1 1", err_spurious_rsp, busy);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0000_0066;
    #1;
    checks++;
    if (ld_fifo_wren !== 1'b1 || ld_fifo_data !== 32'h66) begin
      errors++;
      $display("FAIL spur_real: wren=%b data=%h want 1 00000066", ld_fifo_wren, ld_fifo_data);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (rd_done_cnt !== CNT_W'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL spur_done: rd_cnt=%0d busy=%b want 1 0", rd_done_cnt, busy);
    end
    $display("test_misaligned_spurious done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_counter_wrap();
    int nwrites, bad;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    nwrites = 1 << CNT_W;
    bad     = 0;
    do_reset();
    wr_fifo_empty  = 1'b0;
    res_fifo_empty = 1'b0;
    mem_req_ready  = 1'b1;
    for (int n = 0; n < nwrites; n++) begin
      a             = rand_addr(1'b0);
      d             = $urandom;
      wr_fifo_instr = a;
      res_fifo_data = d;
      tick();
      wr_fifo_instr = $urandom;
      res_fifo_data = $urandom;
      #1;
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== a || mem_req_wdata !== d) bad++;
      tick();
      if (n == nwrites - 2) begin
        #1;
        checks++;
        if (wr_done_cnt !== CNT_W'(nwrites - 1)) begin
          errors++;
          $display("FAIL wrap_max: cnt=%0d want %0d", wr_done_cnt, nwrites - 1);
        end
      end
    end
    #1;
    checks++;
    if (wr_done_cnt !== '0) begin
      errors++;
      $display("FAIL wrap_zero: cnt=%0d want 0", wr_done_cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_reqs: %0d bad write requests want 0", bad);
    end
    wr_fifo_empty  = 1'b1;
    res_fifo_empty = 1'b1;
    mem_req_ready  = 1'b0;
    $display("test_counter_wrap done: %0d writes", nwrites);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [ADDR_W-1:0] rdq[$];
    logic [ADDR_W-1:0] wrq[$];
    logic [DATA_W-1:0] resq[$];
    req_t              pend;
    bit                have_pend, model_idle, exp_mis, exp_wr, exp_rd, wr_ok, rd_ok;
    int                rsp_wait, n_rd, n_wr, cyc;
    logic [DATA_W-1:0] rsp_word;

    ref_mem.delete();
    have_pend  = 0;
    model_idle = 1;
    exp_mis    = 0;
    rsp_wait   = -1;
    n_rd       = 0;
    n_wr       = 0;
    rsp_word   = '0;
    pend       = '0;
    do_reset();

    cyc = 0;
    while (cyc < 1000 || rdq.size() != 0 || wrq.size() != 0 || !model_idle || have_pend) begin
      if (cyc >= 8000) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout: queues rd=%0d wr=%0d not drained", rdq.size(), wrq.size());
        break;
      end
      if (cyc < 1000) begin
        if ($urandom_range(0, 7) == 0) rdq.push_back(rand_addr(1'b1));
        if ($urandom_range(0, 7) == 0) wrq.push_back(rand_addr(1'b1));
        if ($urandom_range(0, 7) == 0) resq.push_back($urandom);
      end else if (resq.size() < wrq.size()) begin
        resq.push_back($urandom);
      end

      rd_fifo_empty  = (rdq.size() == 0);
      rd_fifo_instr  = (rdq.size() != 0) ? rdq[0] : ADDR_W'($urandom);
      wr_fifo_empty  = (wrq.size() == 0);
      wr_fifo_instr  = (wrq.size() != 0) ? wrq[0] : ADDR_W'($urandom);
      res_fifo_empty = (resq.size() == 0);
      res_fifo_data  = (resq.size() != 0) ? resq[0] : DATA_W'($urandom);
      ld_fifo_full   = ($urandom_range(0, 3) == 0);
      mem_req_ready  = $urandom_range(0, 1);
      mem_rsp_valid  = (rsp_wait == 0);
      mem_rsp_rdata  = (rsp_wait == 0) ? rsp_word : DATA_W'($urandom);
      #1;

      wr_ok  = (wrq.size() != 0) && (resq.size() != 0);
      rd_ok  = (rdq.size() != 0) && !ld_fifo_full;
      exp_wr = model_idle && wr_ok;
      exp_rd = model_idle && !wr_ok && rd_ok;

      checks++;
      if (busy !== !model_idle) begin
        errors++;
        $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, !model_idle);
      end
      checks++;
      if ({wr_fifo_rena, res_fifo_rena, rd_fifo_rena} !== {exp_wr, exp_wr, exp_rd}) begin
        errors++;
        $display("FAIL rnd_rena cyc %0d: wr/res/rd got %b want %b", cyc,
                 {wr_fifo_rena, res_fifo_rena, rd_fifo_rena}, {exp_wr, exp_wr, exp_rd});
      end
      checks++;
      if (mem_req_valid !== have_pend) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, mem_req_valid, have_pend);
      end
      if (have_pend && mem_req_valid === 1'b1) begin
        checks++;
        if (mem_req_we !== pend.we || mem_req_addr !== pend.addr || (pend.we && mem_req_wdata !== pend.data)) begin
          errors++;
          $display("FAIL rnd_req cyc %0d: we=%b addr=%h wdata=%h want %b %h %h", cyc,
                   mem_req_we, mem_req_addr, mem_req_wdata, pend.we, pend.addr, pend.data);
        end
      end
      checks++;
      if (ld_fifo_wren !== mem_rsp_valid || (mem_rsp_valid && ld_fifo_data !== rsp_word)) begin
        errors++;
        $display("FAIL rnd_ld cyc %0d: wren=%b data=%h want %b %h", cyc, ld_fifo_wren, ld_fifo_data,
                 mem_rsp_valid, rsp_word);
      end

      // Advance the transaction model to the next cycle.
      if (mem_rsp_valid) begin
        rsp_wait   = -1;
        model_idle = 1;
        n_rd++;
      end else if (rsp_wait > 0) begin
        rsp_wait--;
      end
      if (have_pend && mem_req_ready) begin
        have_pend = 0;
        if (pend.we) begin
          ref_mem[pend.addr] = pend.data;
          model_idle = 1;
          n_wr++;
        end else begin
          rsp_word = ref_mem.exists(pend.addr) ? ref_mem[pend.addr] : ~pend.addr;
          rsp_wait = $urandom_range(0, 3);
        end
      end
      if (exp_wr) begin
        pend.we   = 1'b1;
        pend.addr = {wrq[0][ADDR_W-1:2], 2'b00};
        pend.data = resq[0];
        if (wrq[0][1:0] != 2'b00) exp_mis = 1;
        void'(wrq.pop_front());
        void'(resq.pop_front());
        have_pend  = 1;
        model_idle = 0;
      end else if (exp_rd) begin
        pend.we   = 1'b0;
        pend.addr = {rdq[0][ADDR_W-1:2], 2'b00};
        pend.data = '0;
        if (rdq[0][1:0] != 2'b00) exp_mis = 1;
        void'(rdq.pop_front());
        have_pend  = 1;
        model_idle = 0;
      end
      tick();
      cyc++;
    end

    idle_inputs();
    #1;
    checks++;
    if (rd_done_cnt !== CNT_W'(n_rd) || wr_done_cnt !== CNT_W'(n_wr)) begin
      errors++;
      $display("FAIL rnd_cnt: rd=%0d wr=%0d want %0d %0d", rd_done_cnt, wr_done_cnt,
               CNT_W'(n_rd), CNT_W'(n_wr));
    end
    checks++;
    if (err_misaligned !== exp_mis || err_spurious_rsp !== 1'b0) begin
      errors++;
      $display("FAIL rnd_err: misaligned=%b spurious=%b want %b 0", err_misaligned, err_spurious_rsp, exp_mis);
    end
    $display("test_random done: %0d reads %0d writes in %0d cycles", n_rd, n_wr, cyc);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_reset_mid_read();
    test_single_write();
    test_simultaneous();
    test_write_blocked();
    test_ld_full();
    test_misaligned_spurious();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
